// File: rtl/ram_loader.sv
// ram_loader: loads the 16x8 program RAM from a byte stream over the shared bus.
// Requests a CPU halt for the whole session. For each accepted byte it puts
// the address on the bus and pulses MI, then puts the data on the bus and
// pulses RI.
// Optional feature: define RAM_LOADER_VERIFY_EN to read back every word.
// Each readback uses an address phase (MI) and a read phase (RO), and any
// mismatch sets the sticky err flag. Without the macro, RO and err are tied 0.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, abort        begin a session at address 0 / abandon the session
//   byte_in/valid/ready byte stream handshake (ready only in WAIT_BYTE)
//   bus_in              bus readback (used by the verify build)
//   bus_out, bus_oe     bus drive value and tri-state enable
//   MI, RI, RO          MAR load, RAM write, RAM output strobes
//   halt, busy, done    CPU halt request, session active, completion pulse
//   err                 sticky readback mismatch
// All outputs are registered. They are decoded from the next state, so each
// output lines up with the state the loader is in during that cycle.
module ram_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       MI,
  output logic       RI,
  output logic       RO,
  output logic       halt,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned BUS_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BYTE,
    S_SET_ADDR,
    S_WRITE,
`ifdef RAM_LOADER_VERIFY_EN
    S_V_ADDR,
    S_V_READ,
`endif
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BUS_W-1:0]   data_q, data_d;
  logic               last_word;

  logic               byte_ready_q, byte_ready_d;
  logic [BUS_W-1:0]   bus_out_q, bus_out_d;
  logic               bus_oe_q, bus_oe_d;
  logic               mi_q, mi_d;
  logic               ri_q, ri_d;
  logic               halt_q, halt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef RAM_LOADER_VERIFY_EN
  logic               ro_q, ro_d;
  logic               err_q, err_d;
`else
  logic               unused_bus_in;
  assign unused_bus_in = ^bus_in;
`endif

  // State, counters and output flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      byte_ready_q <= 1'b0;
      bus_out_q    <= '0;
      bus_oe_q     <= 1'b0;
      mi_q         <= 1'b0;
      ri_q         <= 1'b0;
      halt_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
      ro_q         <= 1'b0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      byte_ready_q <= byte_ready_d;
      bus_out_q    <= bus_out_d;
      bus_oe_q     <= bus_oe_d;
      mi_q         <= mi_d;
      ri_q         <= ri_d;
      halt_q       <= halt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef RAM_LOADER_VERIFY_EN
      ro_q         <= ro_d;
      err_q        <= err_d;
`endif
    end
  end

  // Next-state, address/data and output decode
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    byte_ready_d = 1'b0;
    bus_out_d    = '0;
    bus_oe_d     = 1'b0;
    mi_d         = 1'b0;
    ri_d         = 1'b0;
    halt_d       = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
    ro_d         = 1'b0;
    err_d        = err_q;
`endif
    last_word    = (addr_q == ADDR_W'(DEPTH - 1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_BYTE;
          addr_d  = '0;
`ifdef RAM_LOADER_VERIFY_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_WAIT_BYTE: begin
        if (byte_valid) begin
          data_d  = byte_in;
          state_d = S_SET_ADDR;
        end
      end
      S_SET_ADDR: state_d = S_WRITE;
`ifdef RAM_LOADER_VERIFY_EN
      S_WRITE:    state_d = S_V_ADDR;
      S_V_ADDR:   state_d = S_V_READ;
      S_V_READ: begin
        // RAM drives the bus during this cycle; compare at the closing edge
        if (bus_in != data_q) err_d = 1'b1;
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_WAIT_BYTE;
        end
      end
`else
      S_WRITE: begin
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_WAIT_BYTE;
        end
      end
`endif
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Abort wins over everything in an active session
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;

    case (state_d)
      S_WAIT_BYTE: begin
        byte_ready_d = 1'b1;
        halt_d       = 1'b1;
        busy_d       = 1'b1;
      end
      S_SET_ADDR: begin
        bus_out_d = BUS_W'(addr_d);
        bus_oe_d  = 1'b1;
        mi_d      = 1'b1;
        halt_d    = 1'b1;
        busy_d    = 1'b1;
      end
      S_WRITE: begin
        bus_out_d = data_d;
        bus_oe_d  = 1'b1;
        ri_d      = 1'b1;
        halt_d    = 1'b1;
        busy_d    = 1'b1;
      end
`ifdef RAM_LOADER_VERIFY_EN
      S_V_ADDR: begin
        bus_out_d = BUS_W'(addr_d);
        bus_oe_d  = 1'b1;
        mi_d      = 1'b1;
        halt_d    = 1'b1;
        busy_d    = 1'b1;
      end
      S_V_READ: begin
        ro_d   = 1'b1;
        halt_d = 1'b1;
        busy_d = 1'b1;
      end
`endif
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign byte_ready = byte_ready_q;
  assign bus_out    = bus_out_q;
  assign bus_oe     = bus_oe_q;
  assign MI         = mi_q;
  assign RI         = ri_q;
  assign halt       = halt_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef RAM_LOADER_VERIFY_EN
  assign RO         = ro_q;
  assign err        = err_q;
`else
  assign RO         = 1'b0;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Testbench for ram_loader. It holds a 16x8 RAM and MAR model on the bus and
// compares the loaded contents with the byte streams it generated. Session
// latency is checked against the cycle budget per byte, and a monitor counts
// strobes and protocol violations.
module tb_ram_loader;
  localparam int DEPTH = 16;
`ifdef RAM_LOADER_VERIFY_EN
  localparam int CPB = 5;
  localparam int MI_PER_BYTE = 2;
  localparam int RO_PER_BYTE = 1;
`else
  localparam int CPB = 3;
  localparam int MI_PER_BYTE = 1;
  localparam int RO_PER_BYTE = 0;
`endif
  localparam int GAP = 5;

  logic       clk = 1'b0;
  logic       rst, start, abort, byte_valid;
  logic [7:0] byte_in, bus_in, bus_out;
  logic       byte_ready, bus_oe, MI, RI, RO, halt, busy, done, err;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int mi_cnt = 0, ri_cnt = 0, ro_cnt = 0, done_cnt = 0, halt_cnt = 0, viol_cnt = 0;
  int done_cyc = 0;
  logic prev_mi = 1'b0, prev_ri = 1'b0, prev_ro = 1'b0;

  logic [7:0] ram [DEPTH];
  logic [3:0] mar = 4'd0;
  logic       fill_req = 1'b0;
  logic [7:0] fill_base = 8'h00;
  logic       bad5 = 1'b0;
  logic [7:0] sess [DEPTH];

  always #5 clk = ~clk;

  ram_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .MI(MI), .RI(RI), .RO(RO), .halt(halt), .busy(busy), .done(done), .err(err)
  );

  // RAM/MAR model attached to the shared bus
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fill_req) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= fill_base ^ 8'(i);
    end else begin
      if (MI) mar <= bus_out[3:0];
      if (RI) ram[mar] <= bus_out;
    end
  end

  assign bus_in = RO ? ((bad5 && mar == 4'd5) ? 8'h00 : ram[mar]) : 8'h00;

  // Strobe counting and protocol rules, sampled mid-cycle
  always @(negedge clk) begin
    if (MI) mi_cnt++;
    if (RI) ri_cnt++;
    if (RO) ro_cnt++;
    if (halt) halt_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if ((int'(MI) + int'(RI) + int'(RO)) > 1 || (bus_oe && RO) ||
        (bus_oe != (MI || RI)) || (MI && prev_mi) || (RI && prev_ri) ||
        (RO && prev_ro) || (halt != (busy && !done)) ||
        (byte_ready && (MI || RI || RO || bus_oe)) ||
        (MI && bus_out[7:4] != 4'h0) ||
        (!busy && (MI || RI || RO || bus_oe || halt || byte_ready || done)))
      viol_cnt++;
    prev_mi = MI;
    prev_ri = RI;
    prev_ro = RO;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic prefill();
    fill_base = 8'($urandom);
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
  endtask

  task automatic rand_sess();
    for (int i = 0; i < DEPTH; i++) sess[i] = 8'($urandom);
  endtask

  // Present one byte after gap idle cycles and return just after it is taken
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) tick();
    end
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 200) begin tick(); n++; end
    tick();
  endtask

  // Start a session, stream sess[], wait for done; lat = edges start->done or -1
  task automatic load_session(input int gap, input bit poke, output int lat);
    int st, dbase, n;
    tick();
    start = 1'b1;
    byte_in = sess[0];
    byte_valid = (gap == 0);
    tick();
    start = 1'b0;
    st = cyc;
    dbase = done_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      if (poke && i == 8) begin start = 1'b1; tick(); start = 1'b0; end
      send_byte(sess[i], gap);
    end
    byte_valid = 1'b0;
    n = 0;
    while (done_cnt == dbase && n < 400) begin tick(); n++; end
    lat = (done_cnt == dbase) ? -1 : done_cyc - st;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (halt !== 1'b0) begin fails++; $display("FAIL reset_halt got %b exp 0", halt); end
    tests++; if (bus_oe !== 1'b0) begin fails++; $display("FAIL reset_oe got %b exp 0", bus_oe); end
    tests++; if (bus_out !== 8'h00) begin fails++; $display("FAIL reset_bus_out got %h exp 00", bus_out); end
    tests++; if ({MI, RI, RO} !== 3'b000) begin fails++; $display("FAIL reset_strobes got %b exp 000", {MI, RI, RO}); end
    tests++; if ({byte_ready, done, err} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {byte_ready, done, err}); end
    rst = 1'b1;
    repeat (2) tick();
    tests++; if (busy !== 1'b0 || halt !== 1'b0) begin fails++; $display("FAIL reset_release got busy=%b halt=%b exp 0 0", busy, halt); end
  endtask

  task automatic test_full_load();
    int lat, mb, rb, ob, db, hb, vb, bad;
    for (int s = 0; s < 2; s++) begin
      prefill();
      if (s == 0) begin
        for (int i = 0; i < DEPTH; i++) sess[i] = 8'h00;
        sess[0] = 8'h13; sess[1] = 8'hE0; sess[2] = 8'hF0; sess[3] = 8'hAB;
      end else begin
        rand_sess();
      end
      mb = mi_cnt; rb = ri_cnt; ob = ro_cnt; db = done_cnt; hb = halt_cnt; vb = viol_cnt;
      load_session(0, 1'b0, lat);
      tests++; if (lat !== DEPTH * CPB) begin fails++; $display("FAIL full_latency got %0d exp %0d", lat, DEPTH * CPB); end
      tests++; if (halt_cnt - hb !== DEPTH * CPB) begin fails++; $display("FAIL full_halt_cycles got %0d exp %0d", halt_cnt - hb, DEPTH * CPB); end
      tests++; if (done_cnt - db !== 1) begin fails++; $display("FAIL full_done_count got %0d exp 1", done_cnt - db); end
      tests++; if (mi_cnt - mb !== DEPTH * MI_PER_BYTE) begin fails++; $display("FAIL full_mi_count got %0d exp %0d", mi_cnt - mb, DEPTH * MI_PER_BYTE); end
      tests++; if (ri_cnt - rb !== DEPTH) begin fails++; $display("FAIL full_ri_count got %0d exp %0d", ri_cnt - rb, DEPTH); end
      tests++; if (ro_cnt - ob !== DEPTH * RO_PER_BYTE) begin fails++; $display("FAIL full_ro_count got %0d exp %0d", ro_cnt - ob, DEPTH * RO_PER_BYTE); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL full_err got %b exp 0", err); end
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (ram[i] !== sess[i]) bad++;
      tests++; if (bad !== 0) begin fails++; $display("FAIL full_ram %0d words wrong, ram[0..3]=%h %h %h %h exp %h %h %h %h", bad, ram[0], ram[1], ram[2], ram[3], sess[0], sess[1], sess[2], sess[3]); end
      tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_idle_after got busy=%b exp 0", busy); end
      tests++; if (viol_cnt - vb !== 0) begin fails++; $display("FAIL full_protocol got %0d violations exp 0", viol_cnt - vb); end
    end
  endtask

  task automatic test_gapped();
    int lat, mb, rb, vb, bad;
    prefill();
    rand_sess();
    mb = mi_cnt; rb = ri_cnt; vb = viol_cnt;
    load_session(GAP, 1'b0, lat);
    tests++; if (lat !== DEPTH * (GAP + 1) + CPB - 1) begin fails++; $display("FAIL gap_latency got %0d exp %0d", lat, DEPTH * (GAP + 1) + CPB - 1); end
    tests++; if (mi_cnt - mb !== DEPTH * MI_PER_BYTE || ri_cnt - rb !== DEPTH) begin fails++; $display("FAIL gap_strobes got mi=%0d ri=%0d exp %0d %0d", mi_cnt - mb, ri_cnt - rb, DEPTH * MI_PER_BYTE, DEPTH); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== sess[i]) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL gap_ram got %0d wrong words exp 0", bad); end
    tests++; if (viol_cnt - vb !== 0) begin fails++; $display("FAIL gap_protocol got %0d violations exp 0", viol_cnt - vb); end
  endtask

  task automatic test_abort();
    int rb, db, vb, n, bad;
    prefill();
    rand_sess();
    rb = ri_cnt; db = done_cnt; vb = viol_cnt;
    tick();
    start = 1'b1; byte_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(sess[i], int'($urandom_range(0, 3)));
    byte_in = sess[3];
    byte_valid = 1'b1;
    n = 0;
    while (ri_cnt - rb < 3 && n < 100) begin tick(); n++; end
    tests++; if (RI !== 1'b1) begin fails++; $display("FAIL abort_in_write got RI=%b exp 1", RI); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++; if ({busy, bus_oe, halt, done} !== 4'b0000) begin fails++; $display("FAIL abort_release got busy/oe/halt/done=%b exp 0000", {busy, bus_oe, halt, done}); end
    repeat (4) tick();
    byte_valid = 1'b0;
    tests++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin fails++; $display("FAIL abort_stays_idle got busy=%b ready=%b exp 0 0", busy, byte_ready); end
    tests++; if (done_cnt - db !== 0) begin fails++; $display("FAIL abort_no_done got %0d done pulses exp 0", done_cnt - db); end
    tests++; if (ri_cnt - rb !== 3) begin fails++; $display("FAIL abort_ri_count got %0d exp 3", ri_cnt - rb); end
    bad = 0;
    for (int i = 0; i < 3; i++) if (ram[i] !== sess[i]) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL abort_written got %0d wrong of 3 exp 0", bad); end
    bad = 0;
    for (int i = 3; i < DEPTH; i++) if (ram[i] !== (fill_base ^ 8'(i))) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL abort_untouched got %0d changed words exp 0, ram[3]=%h exp %h", bad, ram[3], fill_base ^ 8'd3); end
    tests++; if (viol_cnt - vb !== 0) begin fails++; $display("FAIL abort_protocol got %0d violations exp 0", viol_cnt - vb); end
  endtask

  task automatic test_reset_mid_set();
    int lat, bad;
    prefill();
    rand_sess();
    tick();
    start = 1'b1; byte_valid = 1'b0;
    tick();
    start = 1'b0;
    send_byte(sess[0], 0);
    byte_valid = 1'b0;
    tests++; if (MI !== 1'b1 || bus_oe !== 1'b1) begin fails++; $display("FAIL rstmid_in_set got MI=%b oe=%b exp 1 1", MI, bus_oe); end
    #1 rst = 1'b0;
    #1;
    tests++; if ({MI, RI, RO, bus_oe, halt, busy, done, err, byte_ready} !== 9'd0 || bus_out !== 8'h00) begin fails++; $display("FAIL rstmid_outputs got %b bus=%h exp all 0", {MI, RI, RO, bus_oe, halt, busy, done, err, byte_ready}, bus_out); end
    tick();
    rst = 1'b1;
    tick();
    rand_sess();
    load_session(0, 1'b0, lat);
    tests++; if (lat !== DEPTH * CPB) begin fails++; $display("FAIL rstmid_latency got %0d exp %0d", lat, DEPTH * CPB); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== sess[i]) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL rstmid_ram got %0d wrong words exp 0, ram[0]=%h exp %h", bad, ram[0], sess[0]); end
  endtask

  task automatic test_ignored();
    int lat, mb, rb, db, bad;
    prefill();
    mb = mi_cnt; rb = ri_cnt; db = done_cnt;
    byte_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin byte_in = 8'($urandom); tick(); end
    byte_valid = 1'b0;
    tests++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin fails++; $display("FAIL ign_idle_valid got busy=%b ready=%b exp 0 0", busy, byte_ready); end
    tests++; if (mi_cnt - mb !== 0 || ri_cnt - rb !== 0) begin fails++; $display("FAIL ign_idle_strobes got mi=%0d ri=%0d exp 0 0", mi_cnt - mb, ri_cnt - rb); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== (fill_base ^ 8'(i))) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL ign_idle_ram got %0d changed words exp 0", bad); end
    rand_sess();
    load_session(0, 1'b1, lat);
    tests++; if (lat !== DEPTH * CPB) begin fails++; $display("FAIL ign_start_latency got %0d exp %0d", lat, DEPTH * CPB); end
    tests++; if (done_cnt - db !== 1) begin fails++; $display("FAIL ign_done_count got %0d exp 1", done_cnt - db); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== sess[i]) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL ign_start_ram got %0d wrong words exp 0", bad); end
  endtask

  task automatic test_back_to_back();
    int lat, bad;
    for (int s = 0; s < 2; s++) begin
      rand_sess();
      load_session(0, 1'b0, lat);
      tests++; if (lat !== DEPTH * CPB) begin fails++; $display("FAIL b2b_latency s%0d got %0d exp %0d", s, lat, DEPTH * CPB); end
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (ram[i] !== sess[i]) bad++;
      tests++; if (bad !== 0) begin fails++; $display("FAIL b2b_ram s%0d got %0d wrong words exp 0", s, bad); end
    end
  endtask

`ifdef RAM_LOADER_VERIFY_EN
  task automatic test_verify();
    int lat, db, bad;
    prefill();
    rand_sess();
    sess[5] = sess[5] | 8'h01;
    bad5 = 1'b1;
    db = done_cnt;
    load_session(0, 1'b0, lat);
    bad5 = 1'b0;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL verify_err_set got %b exp 1", err); end
    tests++; if (lat !== DEPTH * CPB || done_cnt - db !== 1) begin fails++; $display("FAIL verify_completes got lat=%0d done=%0d exp %0d 1", lat, done_cnt - db, DEPTH * CPB); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== sess[i]) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL verify_ram got %0d wrong words exp 0", bad); end
    tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL verify_err_sticky got %b exp 1", err); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL verify_err_clear got err=%b busy=%b exp 0 1", err, busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL verify_abort got busy=%b exp 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_gapped();
    test_abort();
    test_reset_mid_set();
    test_ignored();
    test_back_to_back();
`ifdef RAM_LOADER_VERIFY_EN
    test_verify();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
